// File: rtl/tinyml_display_axil_reg_slave_pkg.sv
// Shared types and constants for the display-configuration AXI4-Lite register target.
// The optional SLVERR build is selected by TINYML_AXIL_SLV_SLVERR_EN.
package tinyml_display_axil_reg_slave_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned STATUS_BUSY_BIT = 10;
    localparam int unsigned STATUS_COLL_BIT = 11;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    // Status word layout: only the busy and collision bits are ever non-zero.
    function automatic logic [DATA_W-1:0] status_word(input logic busy, input logic coll);
        logic [DATA_W-1:0] w;
        w = '0;
        w[STATUS_BUSY_BIT] = busy;
        w[STATUS_COLL_BIT] = coll;
        return w;
    endfunction

endpackage

// File: rtl/tinyml_display_axil_busy_timer.sv
// Busy/collision status bits with a countdown that clears both together.
module tinyml_display_axil_busy_timer
    import tinyml_display_axil_reg_slave_pkg::*;
#(
    parameter logic [CNT_W-1:0] BUSY_CYCLES = 16'd64
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd,
    output logic busy,
    output logic coll
);

    logic [CNT_W-1:0] cnt;

    // A new command wins over a same-cycle expiry, so it counts as a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
            coll <= 1'b0;
        end else if (cmd && (BUSY_CYCLES != CNT_W'(0))) begin
            coll <= coll | busy;
            busy <= 1'b1;
            cnt  <= BUSY_CYCLES;
        end else if (cnt != CNT_W'(0)) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                coll <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tinyml_display_axil_reg_slave.sv
// AXI4-Lite register target with a busy status word and a downstream write strobe.
// Define TINYML_AXIL_SLV_SLVERR_EN to answer out-of-range and status writes with SLVERR.
module tinyml_display_axil_reg_slave
    import tinyml_display_axil_reg_slave_pkg::*;
#(
    parameter int unsigned       NUM_REGS    = 9,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = 7'h24,
    parameter logic [CNT_W-1:0]  BUSY_CYCLES = 16'd64
) (
    input  logic              i_axi_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_axi_awaddr,
    input  logic              i_axi_awvalid,
    output logic              o_axi_awready,
    input  logic [DATA_W-1:0] i_axi_wdata,
    input  logic              i_axi_wvalid,
    output logic              o_axi_wready,
    output logic              o_axi_bvalid,
    input  logic              i_axi_bready,
    output logic [1:0]        o_axi_bresp,
    input  logic [ADDR_W-1:0] i_axi_araddr,
    input  logic              i_axi_arvalid,
    output logic              o_axi_arready,
    output logic [DATA_W-1:0] o_axi_rdata,
    output logic              o_axi_rvalid,
    input  logic              i_axi_rready,
    output logic [1:0]        o_axi_rresp,
    output logic              o_wr_strobe,
    output logic [IDX_W-1:0]  o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy
);

    localparam logic [IDX_W-1:0] STATUS_IDX = STATUS_ADDR[ADDR_W-1:2];

    w_state_t          w_state;
    r_state_t          r_state;
    logic [IDX_W-1:0]  aw_idx;
    logic [DATA_W-1:0] w_data;
    logic              aw_got;
    logic              w_got;
    logic [DATA_W-1:0] regs [2**IDX_W];
    logic              coll;

    logic              commit_c;
    logic              wr_ok_c;
    logic [1:0]        wr_resp_c;
    logic [IDX_W-1:0]  ar_idx_c;
    logic [DATA_W-1:0] rd_data_c;
    logic [1:0]        rd_resp_c;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0]};

    // Write decode on the captured address.
    always_comb begin
        wr_ok_c   = (32'(aw_idx) < NUM_REGS) && (aw_idx != STATUS_IDX);
        commit_c  = (w_state == W_IDLE) && aw_got && w_got;
        wr_resp_c = RESP_OKAY;
`ifdef TINYML_AXIL_SLV_SLVERR_EN
        if (!wr_ok_c) begin
            wr_resp_c = RESP_SLVERR;
        end
`endif
    end

    // Read decode straight off the bus; the result is registered at the AR handshake.
    always_comb begin
        ar_idx_c  = i_axi_araddr[ADDR_W-1:2];
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        if (ar_idx_c == STATUS_IDX) begin
            rd_data_c = status_word(o_busy, coll);
        end else if (32'(ar_idx_c) < NUM_REGS) begin
            rd_data_c = regs[ar_idx_c];
        end
`ifdef TINYML_AXIL_SLV_SLVERR_EN
        if ((ar_idx_c != STATUS_IDX) && (32'(ar_idx_c) >= NUM_REGS)) begin
            rd_data_c = 32'hDEAD_0000;
            rd_resp_c = RESP_SLVERR;
        end
`endif
    end

    // Write FSM: independent AW/W capture, commit one edge after both are held.
    always_ff @(posedge i_axi_clk) begin
        if (i_rst) begin
            w_state       <= W_IDLE;
            o_axi_awready <= 1'b0;
            o_axi_wready  <= 1'b0;
            o_axi_bvalid  <= 1'b0;
            o_axi_bresp   <= RESP_OKAY;
            o_wr_strobe   <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            aw_idx        <= '0;
            w_data        <= '0;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            for (int i = 0; i < 2**IDX_W; i++) begin
                regs[i] <= '0;
            end
        end else begin
            o_wr_strobe <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (o_axi_awready && i_axi_awvalid) begin
                        o_axi_awready <= 1'b0;
                        aw_got        <= 1'b1;
                        aw_idx        <= i_axi_awaddr[ADDR_W-1:2];
                    end else if (!aw_got) begin
                        o_axi_awready <= 1'b1;
                    end
                    if (o_axi_wready && i_axi_wvalid) begin
                        o_axi_wready <= 1'b0;
                        w_got        <= 1'b1;
                        w_data       <= i_axi_wdata;
                    end else if (!w_got) begin
                        o_axi_wready <= 1'b1;
                    end
                    if (commit_c) begin
                        if (wr_ok_c) begin
                            regs[aw_idx] <= w_data;
                            o_wr_strobe  <= 1'b1;
                            o_wr_addr    <= aw_idx;
                            o_wr_data    <= w_data;
                        end
                        o_axi_bvalid <= 1'b1;
                        o_axi_bresp  <= wr_resp_c;
                        w_state      <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (i_axi_bready) begin
                        o_axi_bvalid  <= 1'b0;
                        aw_got        <= 1'b0;
                        w_got         <= 1'b0;
                        o_axi_awready <= 1'b1;
                        o_axi_wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: one-cycle latency, data held until RREADY.
    always_ff @(posedge i_axi_clk) begin
        if (i_rst) begin
            r_state       <= R_IDLE;
            o_axi_arready <= 1'b0;
            o_axi_rvalid  <= 1'b0;
            o_axi_rdata   <= '0;
            o_axi_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (o_axi_arready && i_axi_arvalid) begin
                        o_axi_arready <= 1'b0;
                        o_axi_rvalid  <= 1'b1;
                        o_axi_rdata   <= rd_data_c;
                        o_axi_rresp   <= rd_resp_c;
                        r_state       <= R_DATA;
                    end else begin
                        o_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (i_axi_rready) begin
                        o_axi_rvalid  <= 1'b0;
                        o_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    tinyml_display_axil_busy_timer #(
        .BUSY_CYCLES(BUSY_CYCLES)
    ) u_busy_timer (
        .clk (i_axi_clk),
        .rst (i_rst),
        .cmd (commit_c && wr_ok_c),
        .busy(o_busy),
        .coll(coll)
    );

endmodule

// File: tb/tb_tinyml_display_axil_reg_slave.sv
// Randomized bench for tinyml_display_axil_reg_slave against a cycle-stamped reference model.
// Honours TINYML_AXIL_SLV_SLVERR_EN for the expected response codes.
module tb_tinyml_display_axil_reg_slave;

    localparam int NUM_REGS   = 9;
    localparam int STATUS_IDX = 9;
    localparam int BUSY       = 64;
    localparam int TIMEOUT    = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [1:0]  bresp;
    logic [6:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [1:0]  rresp;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;

    tinyml_display_axil_reg_slave dut (
        .i_axi_clk    (clk),
        .i_rst        (rst),
        .i_axi_awaddr (awaddr),
        .i_axi_awvalid(awvalid),
        .o_axi_awready(awready),
        .i_axi_wdata  (wdata),
        .i_axi_wvalid (wvalid),
        .o_axi_wready (wready),
        .o_axi_bvalid (bvalid),
        .i_axi_bready (bready),
        .o_axi_bresp  (bresp),
        .i_axi_araddr (araddr),
        .i_axi_arvalid(arvalid),
        .o_axi_arready(arready),
        .o_axi_rdata  (rdata),
        .o_axi_rvalid (rvalid),
        .i_axi_rready (rready),
        .o_axi_rresp  (rresp),
        .o_wr_strobe  (wr_strobe),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number X, cyc == X.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents, busy deadline (busy after edge X iff X < busy_end), collision flag.
    logic [31:0] exp_regs [32];
    int          busy_end  = 0;
    bit          coll_flag = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        busy_end  = 0;
        coll_flag = 1'b0;
    endfunction

    function automatic bit reg_ok(input logic [4:0] idx);
        return (int'(idx) < NUM_REGS) && (int'(idx) != STATUS_IDX);
    endfunction

    // Value returned by a read whose AR handshake happens on edge x.
    function automatic logic [31:0] exp_read(input logic [4:0] idx, input int x);
        logic [31:0] v;
        bit bp;
        v = '0;
        if (int'(idx) == STATUS_IDX) begin
            bp = (x - 1) < busy_end;
            v[10] = bp;
            v[11] = coll_flag && bp;
        end else if (int'(idx) < NUM_REGS) begin
            v = exp_regs[idx];
        end else begin
`ifdef TINYML_AXIL_SLV_SLVERR_EN
            v = 32'hDEAD_0000;
`endif
        end
        return v;
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [4:0] idx);
`ifdef TINYML_AXIL_SLV_SLVERR_EN
        if (int'(idx) != STATUS_IDX && int'(idx) >= NUM_REGS) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [4:0] idx);
`ifdef TINYML_AXIL_SLV_SLVERR_EN
        if (!reg_ok(idx)) return 2'b10;
`endif
        return 2'b00;
    endfunction

    // Busy output watched every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) check_eq("o_busy", 32'(busy), 32'(cyc < busy_end));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                             input int aw_lag, input int w_lag, input int b_delay);
        int aw_e;
        int w_e;
        int c;
        logic [4:0] idx;
        bit ok;
        idx  = addr[6:2];
        ok   = reg_ok(idx);
        aw_e = -1;
        w_e  = -1;
        fork
            begin
                logic h;
                repeat (aw_lag) tick();
                awaddr  = addr;
                awvalid = 1'b1;
                for (int k = 0; k < TIMEOUT && aw_e < 0; k++) begin
                    h = awready;
                    tick();
                    if (h) begin
                        aw_e    = cyc;
                        awvalid = 1'b0;
                        awaddr  = 7'($urandom);
                        check_eq("awready_drop", 32'(awready), 32'd0);
                    end
                end
            end
            begin
                logic h;
                repeat (w_lag) tick();
                wdata  = data;
                wvalid = 1'b1;
                for (int k = 0; k < TIMEOUT && w_e < 0; k++) begin
                    h = wready;
                    tick();
                    if (h) begin
                        w_e    = cyc;
                        wvalid = 1'b0;
                        wdata  = $urandom;
                        check_eq("wready_drop", 32'(wready), 32'd0);
                    end
                end
            end
        join
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_eq("aw_handshake", 32'(aw_e >= 0), 32'd1);
        check_eq("w_handshake", 32'(w_e >= 0), 32'd1);
        c = ((aw_e > w_e) ? aw_e : w_e) + 1;
        check_eq("bvalid_early", 32'(bvalid), 32'd0);
        check_eq("strobe_early", 32'(wr_strobe), 32'd0);
        tick();
        check_eq("commit_edge", 32'(cyc), 32'(c));
        check_eq("bvalid", 32'(bvalid), 32'd1);
        check_eq("bresp", 32'(bresp), 32'(exp_bresp(idx)));
        check_eq("wr_strobe", 32'(wr_strobe), 32'(ok));
        if (ok) begin
            check_eq("wr_addr", 32'(wr_addr), 32'(idx));
            check_eq("wr_data", wr_data, data);
            exp_regs[idx] = data;
            coll_flag = (c - 1) < busy_end;
            busy_end  = c + BUSY;
        end
        for (int k = 0; k < b_delay; k++) begin
            tick();
            check_eq("bvalid_hold", 32'(bvalid), 32'd1);
            check_eq("strobe_single", 32'(wr_strobe), 32'd0);
            check_eq("awready_while_b", 32'(awready), 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_eq("bvalid_release", 32'(bvalid), 32'd0);
        check_eq("strobe_after", 32'(wr_strobe), 32'd0);
        check_eq("awready_back", 32'(awready), 32'd1);
        check_eq("wready_back", 32'(wready), 32'd1);
    endtask

    task automatic axi_read(input logic [6:0] addr, input int r_delay);
        int x;
        logic h;
        logic [31:0] exp;
        logic [4:0] idx;
        idx     = addr[6:2];
        x       = -1;
        araddr  = addr;
        arvalid = 1'b1;
        for (int k = 0; k < TIMEOUT && x < 0; k++) begin
            h = arready;
            tick();
            if (h) x = cyc;
        end
        arvalid = 1'b0;
        araddr  = 7'($urandom);
        check_eq("ar_handshake", 32'(x >= 0), 32'd1);
        exp = exp_read(idx, x);
        check_eq("rvalid", 32'(rvalid), 32'd1);
        check_eq("rdata", rdata, exp);
        check_eq("rresp", 32'(rresp), 32'(exp_rresp(idx)));
        check_eq("arready_drop", 32'(arready), 32'd0);
        for (int k = 0; k < r_delay; k++) begin
            tick();
            check_eq("rvalid_hold", 32'(rvalid), 32'd1);
            check_eq("rdata_hold", rdata, exp);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check_eq("rvalid_release", 32'(rvalid), 32'd0);
        check_eq("arready_back", 32'(arready), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        model_reset();
        check_eq("rst_awready", 32'(awready), 32'd0);
        check_eq("rst_wready", 32'(wready), 32'd0);
        check_eq("rst_arready", 32'(arready), 32'd0);
        check_eq("rst_bvalid", 32'(bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_strobe", 32'(wr_strobe), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("ready_aw_after_rst", 32'(awready), 32'd1);
        check_eq("ready_w_after_rst", 32'(wready), 32'd1);
        check_eq("ready_ar_after_rst", 32'(arready), 32'd1);
    endtask

    function automatic logic [6:0] rand_addr();
        int r;
        logic [4:0] idx;
        r = int'($urandom_range(0, 9));
        if (r < 7)       idx = 5'($urandom_range(0, NUM_REGS - 1));
        else if (r == 7) idx = 5'(STATUS_IDX);
        else             idx = 5'($urandom_range(NUM_REGS + 1, 31));
        return {idx, 2'($urandom)};
    endfunction

    initial begin
        logic h;
        int x;
        model_reset();
        tick();
        do_reset();

        // Same-cycle AW/W, then readback.
        axi_write(7'h08, 32'h1234_5678, 0, 0, 0);
        axi_read(7'h08, 0);

        // W leads AW by three cycles, response held five cycles.
        axi_write(7'h04, 32'hCAFE_0004, 3, 0, 5);
        axi_read(7'h04, 2);

        // Single command: poll status through the busy window.
        repeat (BUSY + 6) tick();
        axi_write(7'h00, 32'hA5A5_0000, 0, 0, 0);
        for (int i = 0; i < 40; i++) axi_read(7'h24, 0);

        // Two commands back to back: collision, then a clear timed from the second.
        axi_write(7'h0C, 32'h0000_000C, 0, 1, 0);
        tick();
        axi_write(7'h10, 32'h0000_0010, 1, 0, 0);
        for (int i = 0; i < 40; i++) axi_read(7'h26, 0);

        // Out-of-range and read-only status accesses.
        axi_read(7'h3C, 0);
        axi_write(7'h3C, 32'hFFFF_FFFF, 0, 0, 0);
        axi_write(7'h24, 32'hFFFF_FFFF, 0, 0, 1);
        axi_read(7'h24, 0);
        axi_read(7'h21, 1);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 1) == 0)
                axi_write(rand_addr(), $urandom, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                axi_read(rand_addr(), int'($urandom_range(0, 3)));
        end

        // Reset while a read response is pending.
        axi_write(7'h08, 32'h0BAD_F00D, 0, 0, 0);
        araddr  = 7'h08;
        arvalid = 1'b1;
        x = -1;
        for (int k = 0; k < TIMEOUT && x < 0; k++) begin
            h = arready;
            tick();
            if (h) x = cyc;
        end
        arvalid = 1'b0;
        check_eq("mid_ar_handshake", 32'(x >= 0), 32'd1);
        check_eq("mid_rvalid", 32'(rvalid), 32'd1);
        check_eq("mid_rdata", rdata, 32'h0BAD_F00D);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        model_reset();
        rst = 1'b0;
        tick();
        check_eq("mid_rst_arready", 32'(arready), 32'd1);
        for (int i = 0; i < NUM_REGS + 1; i++) axi_read({5'(i), 2'b00}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
